// File: rtl/ysyx_20020207_csr_file_if.sv
// Request/response bundle between the EXU/LSU commit path and the machine-mode CSR file.
// The pipeline side is the master; the CSR file is the slave.
interface ysyx_20020207_csr_file_if;
    logic        lsu_ready;
    logic        wen;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] upc;
    logic        illegal;

    modport master (
        output lsu_ready,
        output wen,
        output csr_op,
        output csr_addr,
        output wdata,
        output pc,
        input  rdata,
        input  upc,
        input  illegal
    );

    modport slave (
        input  lsu_ready,
        input  wen,
        input  csr_op,
        input  csr_addr,
        input  wdata,
        input  pc,
        output rdata,
        output upc,
        output illegal
    );
endinterface

// File: rtl/ysyx_20020207_csr_file.sv
// Machine-mode CSR file: read-then-write CSR ops, trap/return stacking of MIE/MPIE,
// read-only ID registers and a 64-bit free-running mcycle counter.
module ysyx_20020207_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] ARCH_ID     = 32'h0,
    parameter bit          MCYCLE_EN   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_20020207_csr_file_if.slave     bus
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_MRET   = 3'b001,
        OP_ECALL  = 3'b010,
        OP_EBREAK = 3'b011,
        OP_CSRRW  = 3'b100,
        OP_CSRRS  = 3'b101,
        OP_CSRRC  = 3'b110,
        OP_RSVD   = 3'b111
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam int          NUM_ID = 3;
    localparam logic [31:0] MVENDORID = 32'h7973_7978;
    localparam logic [11:0] ID_ADDR [NUM_ID] = '{12'hF11, 12'hF12, 12'hF14};
    localparam logic [31:0] ID_VAL  [NUM_ID] = '{MVENDORID, ARCH_ID, HART_ID};

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    csr_op_e op;
    assign op = csr_op_e'(bus.csr_op);

    // Architectural state; low two bits of mtvec/mepc are kept at zero by masking on write.
    logic        mie_reg,      mie_next;
    logic        mpie_reg,     mpie_next;
    logic [31:0] mtvec_reg,    mtvec_next;
    logic [31:0] mepc_reg,     mepc_next;
    logic [31:0] mcause_reg,   mcause_next;
    logic [31:0] mscratch_reg, mscratch_next;
    logic [63:0] mcycle_reg;

    logic [31:0] mstatus_rd;
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_reg, 3'b0, mie_reg, 3'b0};

    // Read-only ID registers
    logic [NUM_ID-1:0] id_match;
    logic [31:0]       id_data [NUM_ID];
    logic [31:0]       id_rd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ID; gi++) begin : g_id
            assign id_match[gi] = (bus.csr_addr == ID_ADDR[gi]);
            assign id_data[gi]  = id_match[gi] ? ID_VAL[gi] : 32'h0;
        end
    endgenerate

    always_comb begin
        id_rd = 32'h0;
        for (int i = 0; i < NUM_ID; i++) begin
            id_rd = id_rd | id_data[i];
        end
    end

    // Address decode and old-value mux
    logic [31:0] csr_old;
    logic        addr_hit;
    logic        read_only;

    always_comb begin
        csr_old   = 32'h0;
        addr_hit  = 1'b0;
        read_only = 1'b0;
        case (bus.csr_addr)
            ADDR_MSTATUS:  begin addr_hit = 1'b1; csr_old = mstatus_rd;   end
            ADDR_MTVEC:    begin addr_hit = 1'b1; csr_old = mtvec_reg;    end
            ADDR_MSCRATCH: begin addr_hit = 1'b1; csr_old = mscratch_reg; end
            ADDR_MEPC:     begin addr_hit = 1'b1; csr_old = mepc_reg;     end
            ADDR_MCAUSE:   begin addr_hit = 1'b1; csr_old = mcause_reg;   end
            ADDR_MCYCLE: begin
                if (MCYCLE_EN) begin
                    addr_hit = 1'b1;
                    csr_old  = mcycle_reg[31:0];
                end
            end
            ADDR_MCYCLEH: begin
                if (MCYCLE_EN) begin
                    addr_hit = 1'b1;
                    csr_old  = mcycle_reg[63:32];
                end
            end
            default: begin
                if (|id_match) begin
                    addr_hit  = 1'b1;
                    read_only = 1'b1;
                    csr_old   = id_rd;
                end
            end
        endcase
    end

    // Access classification; CSRRS/CSRRC with a zero mask are pure reads
    logic        is_csr_op;
    logic        eff_write;
    logic        illegal;
    logic        commit;
    logic        csr_write;
    logic [31:0] csr_new;

    assign is_csr_op = bus.wen && (op == OP_CSRRW || op == OP_CSRRS || op == OP_CSRRC);
    assign eff_write = (op == OP_CSRRW) || (bus.wdata != 32'h0);
    assign illegal   = is_csr_op && (!addr_hit || (read_only && eff_write));
    assign commit    = bus.lsu_ready && bus.wen;
    assign csr_write = commit && is_csr_op && eff_write && !illegal;

    always_comb begin
        csr_new = csr_old;
        case (op)
            OP_CSRRW: csr_new = bus.wdata;
            OP_CSRRS: csr_new = csr_old | bus.wdata;
            OP_CSRRC: csr_new = csr_old & ~bus.wdata;
            default:  csr_new = csr_old;
        endcase
    end

    // Combinational outputs
    always_comb begin
        bus.upc = 32'h0;
        if (bus.wen) begin
            case (op)
                OP_ECALL, OP_EBREAK: bus.upc = mtvec_reg;
                OP_MRET:             bus.upc = mepc_reg;
                default:             bus.upc = 32'h0;
            endcase
        end
    end

    assign bus.rdata   = illegal ? 32'h0 : csr_old;
    assign bus.illegal = illegal;

    // Next-state: explicit CSR writes, then trap/return side effects
    always_comb begin
        mie_next      = mie_reg;
        mpie_next     = mpie_reg;
        mtvec_next    = mtvec_reg;
        mepc_next     = mepc_reg;
        mcause_next   = mcause_reg;
        mscratch_next = mscratch_reg;

        if (csr_write) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mie_next  = csr_new[3];
                    mpie_next = csr_new[7];
                end
                ADDR_MTVEC:    mtvec_next    = csr_new & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_next = csr_new;
                ADDR_MEPC:     mepc_next     = csr_new & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_next   = csr_new;
                default: ;
            endcase
        end

        if (commit) begin
            case (op)
                OP_ECALL, OP_EBREAK: begin
                    mepc_next   = bus.pc & ALIGN_MASK;
                    mcause_next = (op == OP_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
                    mpie_next   = mie_reg;
                    mie_next    = 1'b0;
                end
                OP_MRET: begin
                    mie_next  = mpie_reg;
                    mpie_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= MTVEC_RESET & ALIGN_MASK;
            mepc_reg     <= 32'h0;
            mcause_reg   <= 32'h0;
            mscratch_reg <= 32'h0;
        end else begin
            mie_reg      <= mie_next;
            mpie_reg     <= mpie_next;
            mtvec_reg    <= mtvec_next;
            mepc_reg     <= mepc_next;
            mcause_reg   <= mcause_next;
            mscratch_reg <= mscratch_next;
        end
    end

    // A committed write to either half holds the whole counter for that cycle.
    generate
        if (MCYCLE_EN) begin : g_mcycle
            logic [63:0] mcycle_next;

            always_comb begin
                mcycle_next = mcycle_reg + 64'd1;
                if (csr_write && bus.csr_addr == ADDR_MCYCLE) begin
                    mcycle_next = {mcycle_reg[63:32], csr_new};
                end else if (csr_write && bus.csr_addr == ADDR_MCYCLEH) begin
                    mcycle_next = {csr_new, mcycle_reg[31:0]};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mcycle_reg <= 64'h0;
                end else begin
                    mcycle_reg <= mcycle_next;
                end
            end
        end else begin : g_no_mcycle
            assign mcycle_reg = 64'h0;
        end
    endgenerate

endmodule
